rf_wr_sched: RTL and testbench

- Write-port scheduler for the register file in the decode/writeback stage.
- Shares the single RF write port between two requesters:
  - the core writeback path (wd_sel result), which has priority and zero latency;
  - a secondary late-result requester (multicycle unit or debug), which uses a valid/ready handshake and is buffered in a small FIFO.
- Detects hazards against pending buffered writes and stalls the core until they drain.
- Sits between the writeback mux / secondary unit and the RF write inputs (rf_we, wR, wD).

---
 rtl/rf_wr_sched.sv | 149 ++++++++++++++
 tb/tb_rf_wr_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_sched.sv
// rf_wr_sched : register-file write-port scheduler.
//
// Shares the single RF write port between two requesters:
//   * the core writeback path, which has priority and zero latency;
//   * a secondary late-result requester (valid/ready), buffered in a FIFO.
// Pending buffered writes are checked against the core's source and
// destination registers. On a hit the core is stalled until the entry drains.
//
// Optional feature (macro RF_WR_BYPASS_EN): when the FIFO is empty and the
// core is not writing, a secondary write goes straight to the RF in the same
// cycle instead of being queued.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   core_we_i/wr_i/wd_i   core writeback request, destination, data
//   core_rr1_i/rr2_i      core source registers (hazard check)
//   sec_valid_i/ready_o   secondary handshake
//   sec_wr_i/wd_i         secondary destination, data
//   rf_we_o/wr_o/wd_o     RF write port
//   stall_o               core must hold PC and instruction
//   pend_cnt_o            number of buffered entries (registered)
module rf_wr_sched #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_we_i,
  input  logic [4:0]    core_wr_i,
  input  logic [31:0]   core_wd_i,
  input  logic [4:0]    core_rr1_i,
  input  logic [4:0]    core_rr2_i,
  input  logic          sec_valid_i,
  output logic          sec_ready_o,
  input  logic [4:0]    sec_wr_i,
  input  logic [31:0]   sec_wd_i,
  output logic          rf_we_o,
  output logic [4:0]    rf_wr_o,
  output logic [31:0]   rf_wd_o,
  output logic          stall_o,
  output logic [AW:0]   pend_cnt_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][4:0]  tag_r;
  logic [DEPTH-1:0][31:0] data_r;
  logic [DEPTH-1:0]       vld_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [AW-1:0]          wr_ptr_r;
  logic [AW:0]            count_r;

  logic stall_s;
  logic core_eff_s;
  logic ready_s;
  logic push_s;
  logic enq_s;
  logic byp_s;
  logic drain_s;

  // A register hits when it is non-zero and matches any valid buffered tag.
  function automatic logic hit_f(input logic [4:0]            r,
                                 input logic [DEPTH-1:0]      vld,
                                 input logic [DEPTH-1:0][4:0] tags);
    logic h;
    h = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      h = h | (vld[i] & (tags[i] == r));
    end
    return h & (r != 5'd0);
  endfunction

  // Hazard detection, handshake and drain/enqueue decisions.
  always_comb begin
    stall_s    = hit_f(core_rr1_i, vld_r, tag_r) |
                 hit_f(core_rr2_i, vld_r, tag_r) |
                 (core_we_i & hit_f(core_wr_i, vld_r, tag_r));
    core_eff_s = core_we_i & (core_wr_i != 5'd0) & ~stall_s;
    // Ready depends only on registered occupancy, never on this cycle's drain.
    ready_s    = (count_r != FULL_CNT);
    push_s     = sec_valid_i & ready_s & (sec_wr_i != 5'd0);
    drain_s    = (count_r != '0) & ~core_eff_s;
`ifdef RF_WR_BYPASS_EN
    byp_s      = push_s & (count_r == '0) & ~core_eff_s;
`else
    byp_s      = 1'b0;
`endif
    enq_s      = push_s & ~byp_s;
  end

  // Write-port mux; all outputs are forced low while reset is asserted.
  always_comb begin
    rf_we_o     = 1'b0;
    rf_wr_o     = 5'd0;
    rf_wd_o     = 32'd0;
    stall_o     = reset & stall_s;
    sec_ready_o = reset & ready_s;
    if (!reset) begin
      rf_we_o = 1'b0;
    end else if (core_eff_s) begin
      rf_we_o = 1'b1;
      rf_wr_o = core_wr_i;
      rf_wd_o = core_wd_i;
    end else if (drain_s) begin
      rf_we_o = 1'b1;
      rf_wr_o = tag_r[rd_ptr_r];
      rf_wd_o = data_r[rd_ptr_r];
    end else if (byp_s) begin
      rf_we_o = 1'b1;
      rf_wr_o = sec_wr_i;
      rf_wd_o = sec_wd_i;
    end else begin
      rf_we_o = 1'b0;
    end
  end

  assign pend_cnt_o = count_r;

  // FIFO storage, pointers and occupancy; reset discards pending entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_r    <= '0;
      data_r   <= '0;
      vld_r    <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      // Enqueue and dequeue never touch the same slot: a drain needs a
      // non-empty FIFO, and a non-full, non-empty FIFO has wr_ptr != rd_ptr.
      if (enq_s) begin
        tag_r[wr_ptr_r]  <= sec_wr_i;
        data_r[wr_ptr_r] <= sec_wd_i;
        vld_r[wr_ptr_r]  <= 1'b1;
        wr_ptr_r         <= wr_ptr_r + AW'(1);
      end
      if (drain_s) begin
        vld_r[rd_ptr_r]  <= 1'b0;
        rd_ptr_r         <= rd_ptr_r + AW'(1);
      end
      case ({enq_s, drain_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wr_sched.sv
module tb_rf_wr_sched;

  logic        clk;
  logic        reset;
  logic        core_we_i;
  logic [4:0]  core_wr_i;
  logic [31:0] core_wd_i;
  logic [4:0]  core_rr1_i;
  logic [4:0]  core_rr2_i;
  logic        sec_valid_i;
  logic        sec_ready_o;
  logic [4:0]  sec_wr_i;
  logic [31:0] sec_wd_i;
  logic        rf_we_o;
  logic [4:0]  rf_wr_o;
  logic [31:0] rf_wd_o;
  logic        stall_o;
  logic [2:0]  pend_cnt_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  rf_wr_sched #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset),
    .core_we_i(core_we_i), .core_wr_i(core_wr_i), .core_wd_i(core_wd_i),
    .core_rr1_i(core_rr1_i), .core_rr2_i(core_rr2_i),
    .sec_valid_i(sec_valid_i), .sec_ready_o(sec_ready_o),
    .sec_wr_i(sec_wr_i), .sec_wd_i(sec_wd_i),
    .rf_we_o(rf_we_o), .rf_wr_o(rf_wr_o), .rf_wd_o(rf_wd_o),
    .stall_o(stall_o), .pend_cnt_o(pend_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled mid-cycle, well away from the rising edge.
  task automatic settle();
    #2;
  endtask

  task automatic idle();
    core_we_i = 1'b0; core_wr_i = 5'd0; core_wd_i = 32'd0;
    core_rr1_i = 5'd0; core_rr2_i = 5'd0;
    sec_valid_i = 1'b0; sec_wr_i = 5'd0; sec_wd_i = 32'd0;
  endtask

  task automatic core(input logic [4:0] wr, input logic [31:0] wd);
    core_we_i = 1'b1; core_wr_i = wr; core_wd_i = wd;
  endtask

  task automatic sec(input logic [4:0] wr, input logic [31:0] wd);
    sec_valid_i = 1'b1; sec_wr_i = wr; sec_wd_i = wd;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    core(5'd5, 32'h1234_5678);
    sec(5'd6, 32'h0000_0066);
    settle();
    vec_cnt++; if (rf_we_o !== 1'b0) begin err_cnt++; $display("FAIL rst_we got %b want 0", rf_we_o); end
    vec_cnt++; if (rf_wr_o !== 5'd0 || rf_wd_o !== 32'd0) begin err_cnt++; $display("FAIL rst_addr got %0d/%h want 0/0", rf_wr_o, rf_wd_o); end
    vec_cnt++; if (sec_ready_o !== 1'b0 || stall_o !== 1'b0) begin err_cnt++; $display("FAIL rst_rdy_stall got %b/%b want 0/0", sec_ready_o, stall_o); end
    tick();
    tick();
    vec_cnt++; if (pend_cnt_o !== 3'd0) begin err_cnt++; $display("FAIL rst_pend got %0d want 0", pend_cnt_o); end
    idle();
    reset = 1'b1;
  endtask

  task automatic test_core_write();
    core(5'd5, 32'hA5A5_0001);
    settle();
    vec_cnt++; if (rf_we_o !== 1'b1 || rf_wr_o !== 5'd5 || rf_wd_o !== 32'hA5A5_0001) begin err_cnt++; $display("FAIL core_wr got %b/%0d/%h want 1/5/a5a50001", rf_we_o, rf_wr_o, rf_wd_o); end
    vec_cnt++; if (stall_o !== 1'b0 || pend_cnt_o !== 3'd0 || sec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL core_stat got stall %b pend %0d rdy %b want 0/0/1", stall_o, pend_cnt_o, sec_ready_o); end
    tick();
    idle();
  endtask

  task automatic test_contention();
    core(5'd3, 32'h0000_3333);
    sec(5'd7, 32'h0000_1111);
    settle();
    vec_cnt++; if (rf_wr_o !== 5'd3 || rf_wd_o !== 32'h0000_3333 || sec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL cont_c0 got %0d/%h rdy %b want 3/3333/1", rf_wr_o, rf_wd_o, sec_ready_o); end
    tick();
    sec(5'd8, 32'h0000_2222);
    settle();
    vec_cnt++; if (rf_wr_o !== 5'd3 || pend_cnt_o !== 3'd1) begin err_cnt++; $display("FAIL cont_c1 got %0d pend %0d want 3/1", rf_wr_o, pend_cnt_o); end
    tick();
    sec_valid_i = 1'b0;
    settle();
    vec_cnt++; if (rf_we_o !== 1'b1 || rf_wr_o !== 5'd3 || pend_cnt_o !== 3'd2) begin err_cnt++; $display("FAIL cont_c2 got %b/%0d pend %0d want 1/3/2", rf_we_o, rf_wr_o, pend_cnt_o); end
    tick();
    idle();
    settle();
    vec_cnt++; if (rf_we_o !== 1'b1 || rf_wr_o !== 5'd7 || rf_wd_o !== 32'h0000_1111 || pend_cnt_o !== 3'd2) begin err_cnt++; $display("FAIL cont_d7 got %b/%0d/%h pend %0d want 1/7/1111/2", rf_we_o, rf_wr_o, rf_wd_o, pend_cnt_o); end
    tick();
    settle();
    vec_cnt++; if (rf_we_o !== 1'b1 || rf_wr_o !== 5'd8 || rf_wd_o !== 32'h0000_2222 || pend_cnt_o !== 3'd1) begin err_cnt++; $display("FAIL cont_d8 got %b/%0d/%h pend %0d want 1/8/2222/1", rf_we_o, rf_wr_o, rf_wd_o, pend_cnt_o); end
    tick();
    settle();
    vec_cnt++; if (rf_we_o !== 1'b0 || pend_cnt_o !== 3'd0) begin err_cnt++; $display("FAIL cont_end got %b pend %0d want 0/0", rf_we_o, pend_cnt_o); end
    tick();
  endtask

  task automatic test_raw_stall();
    core(5'd4, 32'h0000_4444);
    sec(5'd9, 32'h0000_DEAD);
    settle();
    vec_cnt++; if (rf_wr_o !== 5'd4 || stall_o !== 1'b0) begin err_cnt++; $display("FAIL raw_c0 got %0d stall %b want 4/0", rf_wr_o, stall_o); end
    tick();
    sec_valid_i = 1'b0;
    core_rr1_i = 5'd9;
    settle();
    vec_cnt++; if (stall_o !== 1'b1 || rf_we_o !== 1'b1 || rf_wr_o !== 5'd9 || rf_wd_o !== 32'h0000_DEAD) begin err_cnt++; $display("FAIL raw_stall got %b/%b/%0d/%h want 1/1/9/dead", stall_o, rf_we_o, rf_wr_o, rf_wd_o); end
    tick();
    settle();
    vec_cnt++; if (stall_o !== 1'b0 || rf_wr_o !== 5'd4 || rf_wd_o !== 32'h0000_4444 || pend_cnt_o !== 3'd0) begin err_cnt++; $display("FAIL raw_after got %b/%0d/%h pend %0d want 0/4/4444/0", stall_o, rf_wr_o, rf_wd_o, pend_cnt_o); end
    tick();
    idle();
  endtask

  task automatic test_waw_stall();
    core(5'd2, 32'h0000_0002);
    sec(5'd15, 32'h0000_F0F0);
    tick();
    sec_valid_i = 1'b0;
    core(5'd15, 32'h0000_0F0F);
    settle();
    vec_cnt++; if (stall_o !== 1'b1 || rf_wr_o !== 5'd15 || rf_wd_o !== 32'h0000_F0F0) begin err_cnt++; $display("FAIL waw_stall got %b/%0d/%h want 1/15/f0f0", stall_o, rf_wr_o, rf_wd_o); end
    tick();
    settle();
    vec_cnt++; if (stall_o !== 1'b0 || rf_wr_o !== 5'd15 || rf_wd_o !== 32'h0000_0F0F) begin err_cnt++; $display("FAIL waw_after got %b/%0d/%h want 0/15/0f0f", stall_o, rf_wr_o, rf_wd_o); end
    tick();
    idle();
  endtask

  task automatic test_full();
    logic [4:0] exp_tag;
    core(5'd1, 32'h0000_0001);
    for (int i = 0; i < 4; i++) begin
      exp_tag = 5'd10 + 5'(i);
      sec(exp_tag, 32'h0000_00A0 + 32'(i));
      settle();
      vec_cnt++; if (sec_ready_o !== 1'b1 || pend_cnt_o !== 3'(i) || rf_wr_o !== 5'd1) begin err_cnt++; $display("FAIL full_acc%0d got rdy %b pend %0d wr %0d want 1/%0d/1", i, sec_ready_o, pend_cnt_o, rf_wr_o, i); end
      tick();
    end
    sec(5'd14, 32'h0000_00A4);
    settle();
    vec_cnt++; if (sec_ready_o !== 1'b0 || pend_cnt_o !== 3'd4 || rf_wr_o !== 5'd1) begin err_cnt++; $display("FAIL full_hold got rdy %b pend %0d wr %0d want 0/4/1", sec_ready_o, pend_cnt_o, rf_wr_o); end
    tick();
    core_we_i = 1'b0;
    settle();
    vec_cnt++; if (sec_ready_o !== 1'b0 || rf_we_o !== 1'b1 || rf_wr_o !== 5'd10 || rf_wd_o !== 32'h0000_00A0) begin err_cnt++; $display("FAIL full_drain got rdy %b %b/%0d/%h want 0/1/10/a0", sec_ready_o, rf_we_o, rf_wr_o, rf_wd_o); end
    tick();
    core_we_i = 1'b1;
    settle();
    vec_cnt++; if (sec_ready_o !== 1'b1 || pend_cnt_o !== 3'd3 || rf_wr_o !== 5'd1) begin err_cnt++; $display("FAIL full_reacc got rdy %b pend %0d wr %0d want 1/3/1", sec_ready_o, pend_cnt_o, rf_wr_o); end
    tick();
    sec_valid_i = 1'b0;
    settle();
    vec_cnt++; if (sec_ready_o !== 1'b0 || pend_cnt_o !== 3'd4) begin err_cnt++; $display("FAIL full_again got rdy %b pend %0d want 0/4", sec_ready_o, pend_cnt_o); end
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      exp_tag = 5'd11 + 5'(i);
      settle();
      vec_cnt++; if (rf_we_o !== 1'b1 || rf_wr_o !== exp_tag || rf_wd_o !== 32'h0000_00A1 + 32'(i)) begin err_cnt++; $display("FAIL full_out%0d got %b/%0d/%h want 1/%0d/%h", i, rf_we_o, rf_wr_o, rf_wd_o, exp_tag, 32'h0000_00A1 + 32'(i)); end
      tick();
    end
    settle();
    vec_cnt++; if (pend_cnt_o !== 3'd0 || rf_we_o !== 1'b0) begin err_cnt++; $display("FAIL full_empty got pend %0d we %b want 0/0", pend_cnt_o, rf_we_o); end
  endtask

  task automatic test_x0();
    idle();
    sec(5'd0, 32'hFFFF_FFFF);
    settle();
    vec_cnt++; if (sec_ready_o !== 1'b1 || rf_we_o !== 1'b0) begin err_cnt++; $display("FAIL x0_acc got rdy %b we %b want 1/0", sec_ready_o, rf_we_o); end
    tick();
    idle();
    settle();
    vec_cnt++; if (pend_cnt_o !== 3'd0 || rf_we_o !== 1'b0) begin err_cnt++; $display("FAIL x0_after got pend %0d we %b want 0/0", pend_cnt_o, rf_we_o); end
    tick();
  endtask

  task automatic test_mid_reset();
    core(5'd2, 32'h0000_0022);
    for (int i = 0; i < 3; i++) begin
      sec(5'd20 + 5'(i), 32'h0000_0200 + 32'(i));
      tick();
    end
    idle();
    reset = 1'b0;
    settle();
    vec_cnt++; if (pend_cnt_o !== 3'd3 || rf_we_o !== 1'b0 || sec_ready_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_low got pend %0d we %b rdy %b want 3/0/0", pend_cnt_o, rf_we_o, sec_ready_o); end
    tick();
    reset = 1'b1;
    settle();
    vec_cnt++; if (pend_cnt_o !== 3'd0 || rf_we_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_rel got pend %0d we %b want 0/0", pend_cnt_o, rf_we_o); end
    tick();
    settle();
    vec_cnt++; if (rf_we_o !== 1'b0 || stall_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_quiet got we %b stall %b want 0/0", rf_we_o, stall_o); end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    sec(5'd12, 32'h0000_CAFE);
    settle();
`ifdef RF_WR_BYPASS_EN
    vec_cnt++; if (rf_we_o !== 1'b1 || rf_wr_o !== 5'd12 || rf_wd_o !== 32'h0000_CAFE) begin err_cnt++; $display("FAIL byp_now got %b/%0d/%h want 1/12/cafe", rf_we_o, rf_wr_o, rf_wd_o); end
    tick();
    idle();
    settle();
    vec_cnt++; if (pend_cnt_o !== 3'd0 || rf_we_o !== 1'b0) begin err_cnt++; $display("FAIL byp_after got pend %0d we %b want 0/0", pend_cnt_o, rf_we_o); end
`else
    vec_cnt++; if (rf_we_o !== 1'b0) begin err_cnt++; $display("FAIL nobyp_now got we %b want 0", rf_we_o); end
    tick();
    idle();
    settle();
    vec_cnt++; if (rf_we_o !== 1'b1 || rf_wr_o !== 5'd12 || rf_wd_o !== 32'h0000_CAFE || pend_cnt_o !== 3'd1) begin err_cnt++; $display("FAIL nobyp_late got %b/%0d/%h pend %0d want 1/12/cafe/1", rf_we_o, rf_wr_o, rf_wd_o, pend_cnt_o); end
    tick();
    settle();
    vec_cnt++; if (pend_cnt_o !== 3'd0 || rf_we_o !== 1'b0) begin err_cnt++; $display("FAIL nobyp_after got pend %0d we %b want 0/0", pend_cnt_o, rf_we_o); end
`endif
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #1;
    test_reset();
    test_core_write();
    test_contention();
    test_raw_stall();
    test_waw_stall();
    test_full();
    test_x0();
    test_mid_reset();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
